decred_spi_master: RTL and testbench

SPI master that issues single-register read and write frames to a downstream miner chip's SPI slave port, which is the host end of the same link the miner controller terminates. It sits on the host/test side and drives the client lines SCSN, SCLK and MOSI, and samples MISO. Frames are 16-bit, mode 0 (CPOL=0, CPHA=0), MSB first, one register access per chip-select assertion. The command/response side is a simple valid/ready handshake for a local sequencer or test harness.

---
 rtl/decred_spi_master.sv | 164 ++++++++++++++++
 tb/tb_decred_spi_master.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decred_spi_master.sv
// SPI master for single-register read/write frames to a miner chip's SPI slave port.
// Frames are 16 bits, mode 0 (CPOL=0, CPHA=0), MSB first, one access per chip-select.
// Frame layout: bit15 = write flag, bits14..8 = address, bits7..0 = write data (0x00 on reads).
//
// Parameters:
//   ClkDiv       SCLK half-period in clk_i cycles (1..255)
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        asynchronous active-high reset
//   cmd_valid_i  command request; cmd_ready_o high while idle
//   cmd_write_i  1 = register write, 0 = register read
//   cmd_addr_i   7-bit register address
//   cmd_wdata_i  write data, ignored for reads
//   rsp_valid_o  one-cycle pulse on the last cycle of a frame
//   rsp_rdata_o  last 8 bits sampled from MISO, held until the next frame ends
//   busy_o       high from command accept through rsp_valid_o
//   scsn_o       active-low chip select
//   sclk_o       SPI clock
//   mosi_o       serial data out
//   miso_i       serial data in, already synchronous to clk_i
module decred_spi_master #(
  parameter int unsigned ClkDiv = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic       cmd_write_i,
  input  logic [6:0] cmd_addr_i,
  input  logic [7:0] cmd_wdata_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_rdata_o,
  output logic       busy_o,
  output logic       scsn_o,
  output logic       sclk_o,
  output logic       mosi_o,
  input  logic       miso_i
);

  localparam logic [7:0] PhaseLoad = 8'(ClkDiv - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StHigh,
    StLow,
    StHold,
    StGap
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  phase_q, phase_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        phase_done;

  assign phase_done = (phase_q == 8'd0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      phase_q   <= 8'd0;
      bit_cnt_q <= 5'd0;
      tx_q      <= 16'd0;
      rx_q      <= 8'd0;
      rdata_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rdata_d   = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          tx_d      = {cmd_write_i, cmd_addr_i, cmd_write_i ? cmd_wdata_i : 8'h00};
          phase_d   = PhaseLoad;
          bit_cnt_d = 5'd0;
          state_d   = StSetup;
        end
      end
      StSetup: begin
        if (phase_done) begin
          phase_d = PhaseLoad;
          state_d = StHigh;
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      StHigh: begin
        if (phase_done) begin
          // Sample on the last high cycle, just before SCLK falls.
          rx_d      = {rx_q[6:0], miso_i};
          bit_cnt_d = bit_cnt_q + 5'd1;
          phase_d   = PhaseLoad;
          if (bit_cnt_q == 5'd15) begin
            state_d = StHold;
          end else begin
            // Advance MOSI together with the falling SCLK edge.
            tx_d    = {tx_q[14:0], 1'b0};
            state_d = StLow;
          end
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      StLow: begin
        if (phase_done) begin
          phase_d = PhaseLoad;
          state_d = StHigh;
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      StHold: begin
        if (phase_done) begin
          rdata_d = rx_q;
          phase_d = PhaseLoad;
          state_d = StGap;
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      StGap: begin
        if (phase_done) begin
          phase_d   = 8'd0;
          bit_cnt_d = 5'd0;
          state_d   = StIdle;
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      default: begin
        phase_d   = 8'd0;
        bit_cnt_d = 5'd0;
        state_d   = StIdle;
      end
    endcase
  end

  // Outputs decode straight from state so reset forces SCSN high / SCLK low at once.
  assign cmd_ready_o = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);
  assign scsn_o      = (state_q == StIdle) || (state_q == StGap);
  assign sclk_o      = (state_q == StHigh);
  assign mosi_o      = ((state_q == StIdle) || (state_q == StGap)) ? 1'b0 : tx_q[15];
  assign rsp_valid_o = (state_q == StGap) && phase_done;
  assign rsp_rdata_o = rdata_q;

endmodule

// File: tb/tb_decred_spi_master.sv
// Bench for decred_spi_master: three instances (ClkDiv 2, 1, 255) with a slave model each.
module tb_decred_spi_master;

  localparam int NI = 3;

  logic       clk;
  logic       rst       [NI];
  logic       cmd_valid [NI];
  logic       cmd_ready [NI];
  logic       cmd_write [NI];
  logic [6:0] cmd_addr  [NI];
  logic [7:0] cmd_wdata [NI];
  logic       rsp_valid [NI];
  logic [7:0] rsp_rdata [NI];
  logic       busy      [NI];
  logic       scsn      [NI];
  logic       sclk      [NI];
  logic       mosi      [NI];
  logic       miso      [NI];

  // Slave model state (written only by the monitor, except sdata which the stimulus sets).
  logic [15:0] sdata     [NI];
  logic [15:0] rx_word   [NI];
  logic [15:0] last_frame[NI];
  int cnt[NI], rise_tot[NI], low_cnt[NI], last_low[NI];
  int acc_cnt[NI], acc_last[NI], rsp_cnt[NI], rsp_last[NI], rsp_prev[NI];
  int busy_run[NI], busy_at_rsp[NI], viol[NI];
  int scsn_rise_cyc[NI], last_gap[NI], rise_cyc[NI], fall_cyc[NI];
  int hi_min[NI] = '{9999, 9999, 9999};
  int hi_max[NI] = '{0, 0, 0};
  int lo_min[NI] = '{9999, 9999, 9999};
  int lo_max[NI] = '{0, 0, 0};
  logic sclk_p[NI], scsn_p[NI], mosi_p[NI];
  int cyc;

  int n_checks;
  int n_fail;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    decred_spi_master #(
      .ClkDiv((g == 0) ? 2 : (g == 1) ? 1 : 255)
    ) u_dut (
      .clk_i      (clk),
      .rst_i      (rst[g]),
      .cmd_valid_i(cmd_valid[g]),
      .cmd_ready_o(cmd_ready[g]),
      .cmd_write_i(cmd_write[g]),
      .cmd_addr_i (cmd_addr[g]),
      .cmd_wdata_i(cmd_wdata[g]),
      .rsp_valid_o(rsp_valid[g]),
      .rsp_rdata_o(rsp_rdata[g]),
      .busy_o     (busy[g]),
      .scsn_o     (scsn[g]),
      .sclk_o     (sclk[g]),
      .mosi_o     (mosi[g]),
      .miso_i     (miso[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave drives bit (15 - i) of sdata while SCLK high for bit i.
  always_comb begin
    for (int k = 0; k < NI; k++) begin
      if (cnt[k] >= 1 && cnt[k] <= 16) miso[k] = sdata[k][16 - cnt[k]];
      else                             miso[k] = 1'b0;
    end
  end

  initial begin
    for (int k = 0; k < NI; k++) begin
      cnt[k] = 0; rise_tot[k] = 0; low_cnt[k] = 0; last_low[k] = 0;
      acc_cnt[k] = 0; acc_last[k] = 0; rsp_cnt[k] = 0; rsp_last[k] = 0; rsp_prev[k] = 0;
      busy_run[k] = 0; busy_at_rsp[k] = 0; viol[k] = 0;
      scsn_rise_cyc[k] = 0; last_gap[k] = 0; rise_cyc[k] = 0; fall_cyc[k] = 0;
      rx_word[k] = '0; last_frame[k] = '0;
      sclk_p[k] = 1'b0; scsn_p[k] = 1'b1; mosi_p[k] = 1'b0;
    end
  end

  // Monitor on the falling clock edge, away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (sclk[k] && (mosi[k] != mosi_p[k])) viol[k]++;
      if (sclk[k] && !sclk_p[k]) begin
        if (cnt[k] > 0) begin
          if (cyc - fall_cyc[k] < lo_min[k]) lo_min[k] = cyc - fall_cyc[k];
          if (cyc - fall_cyc[k] > lo_max[k]) lo_max[k] = cyc - fall_cyc[k];
        end
        cnt[k]++;
        rise_tot[k]++;
        rise_cyc[k] = cyc;
        rx_word[k] = {rx_word[k][14:0], mosi[k]};
      end
      if (!sclk[k] && sclk_p[k]) begin
        fall_cyc[k] = cyc;
        if (cyc - rise_cyc[k] < hi_min[k]) hi_min[k] = cyc - rise_cyc[k];
        if (cyc - rise_cyc[k] > hi_max[k]) hi_max[k] = cyc - rise_cyc[k];
      end
      if (!scsn[k]) low_cnt[k]++;
      if (scsn[k] && !scsn_p[k]) begin
        last_frame[k]    = rx_word[k];
        last_low[k]      = low_cnt[k];
        scsn_rise_cyc[k] = cyc;
      end
      if (!scsn[k] && scsn_p[k]) last_gap[k] = cyc - scsn_rise_cyc[k];
      if (scsn[k]) begin
        cnt[k]     = 0;
        low_cnt[k] = 0;
      end
      if (cmd_valid[k] && cmd_ready[k]) begin
        acc_cnt[k]++;
        acc_last[k] = cyc;
        busy_run[k] = 0;
      end else if (busy[k]) begin
        busy_run[k]++;
      end
      if (rsp_valid[k]) begin
        rsp_cnt[k]++;
        rsp_prev[k]    = rsp_last[k];
        rsp_last[k]    = cyc;
        busy_at_rsp[k] = busy_run[k];
      end
      sclk_p[k] = sclk[k];
      scsn_p[k] = scsn[k];
      mosi_p[k] = mosi[k];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one command on instance k and wait for its response pulse.
  task automatic run_cmd(input int k, input logic w, input logic [6:0] a, input logic [7:0] d,
                         input logic [15:0] sd);
    int  a0;
    int  r0;
    logic ok;
    a0 = acc_cnt[k];
    r0 = rsp_cnt[k];
    @(posedge clk); #1;
    sdata[k] = sd; cmd_write[k] = w; cmd_addr[k] = a; cmd_wdata[k] = d; cmd_valid[k] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (acc_cnt[k] != a0) begin ok = 1'b1; break; end
    end
    cmd_valid[k] = 1'b0;
    check_eq("accept_seen", 32'(ok), 32'd1);
    ok = 1'b0;
    for (int i = 0; i < 9000; i++) begin
      @(posedge clk); #1;
      if (rsp_cnt[k] != r0) begin ok = 1'b1; break; end
    end
    check_eq("rsp_seen", 32'(ok), 32'd1);
  endtask

  initial begin
    int a0;
    int r0;
    logic ok;
    n_checks = 0;
    n_fail   = 0;
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; cmd_valid[k] = 1'b0; cmd_write[k] = 1'b0;
      cmd_addr[k] = '0; cmd_wdata[k] = '0; sdata[k] = '0;
    end

    // Reset then idle.
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) rst[k] = 1'b0;
    check_eq("rst_scsn", 32'(scsn[0]), 32'd1);
    check_eq("rst_sclk", 32'(sclk[0]), 32'd0);
    check_eq("rst_mosi", 32'(mosi[0]), 32'd0);
    check_eq("rst_ready", 32'(cmd_ready[0]), 32'd1);
    check_eq("rst_busy", 32'(busy[0]), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check_eq("rst_rdata", 32'(rsp_rdata[0]), 32'h00);
    repeat (100) @(posedge clk);
    #1;
    check_eq("idle_no_sclk", 32'(rise_tot[0] + rise_tot[1] + rise_tot[2]), 32'd0);

    // Write, ClkDiv=2: 1_0010101_10100101 = 0x95A5.
    run_cmd(0, 1'b1, 7'h15, 8'hA5, 16'h0000);
    check_eq("wr_frame", 32'(last_frame[0]), 32'h95A5);
    check_eq("wr_scsn_low", 32'(last_low[0]), 32'd66);
    check_eq("wr_rsp_time", 32'(rsp_last[0] - acc_last[0]), 32'd68);

    // Read, ClkDiv=2: 0_1111111_00000000 = 0x7F00, slave returns 0x3C.
    run_cmd(0, 1'b0, 7'h7F, 8'hEE, 16'h003C);
    check_eq("rd_frame", 32'(last_frame[0]), 32'h7F00);
    check_eq("rd_rdata", 32'(rsp_rdata[0]), 32'h3C);
    check_eq("rd_busy_len", 32'(busy_at_rsp[0]), 32'd68);
    check_eq("rd_busy_after", 32'(busy[0]), 32'd0);
    check_eq("rd_ready_after", 32'(cmd_ready[0]), 32'd1);

    // Back-to-back, ClkDiv=1, cmd_valid held across two frames.
    a0 = acc_cnt[1];
    r0 = rsp_cnt[1];
    @(posedge clk); #1;
    sdata[1] = 16'h00A7; cmd_write[1] = 1'b1; cmd_addr[1] = 7'h33; cmd_wdata[1] = 8'h0F;
    cmd_valid[1] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (acc_cnt[1] == a0 + 2) begin ok = 1'b1; break; end
    end
    cmd_valid[1] = 1'b0;
    check_eq("b2b_two_accepts", 32'(ok), 32'd1);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (rsp_cnt[1] == r0 + 2) begin ok = 1'b1; break; end
    end
    check_eq("b2b_two_rsps", 32'(ok), 32'd1);
    check_eq("b2b_accept_after_rsp", 32'(acc_last[1] - rsp_prev[1]), 32'd1);
    // Between frames SCSN is high for the GAP cycle plus the accept cycle in IDLE.
    check_eq("b2b_scsn_gap", 32'(last_gap[1]), 32'd2);
    check_eq("b2b_scsn_low", 32'(last_low[1]), 32'd33);
    check_eq("b2b_rsp_time", 32'(rsp_last[1] - acc_last[1]), 32'd34);
    check_eq("b2b_frame", 32'(last_frame[1]), 32'hB30F);
    check_eq("b2b_rdata", 32'(rsp_rdata[1]), 32'hA7);
    repeat (80) @(posedge clk);
    #1;
    check_eq("b2b_no_third", 32'(acc_cnt[1] - a0), 32'd2);

    // Mid-frame reset on instance 0 after the 7th SCLK rise.
    r0 = rsp_cnt[0];
    @(posedge clk); #1;
    sdata[0] = 16'h0000; cmd_write[0] = 1'b1; cmd_addr[0] = 7'h11; cmd_wdata[0] = 8'h22;
    cmd_valid[0] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      cmd_valid[0] = 1'b0;
      if (cnt[0] == 7) begin ok = 1'b1; break; end
    end
    check_eq("mrst_reached_rise7", 32'(ok), 32'd1);
    rst[0] = 1'b1;
    #1;
    check_eq("mrst_scsn", 32'(scsn[0]), 32'd1);
    check_eq("mrst_sclk", 32'(sclk[0]), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    check_eq("mrst_ready", 32'(cmd_ready[0]), 32'd1);
    repeat (100) @(posedge clk);
    #1;
    check_eq("mrst_no_rsp", 32'(rsp_cnt[0] - r0), 32'd0);
    // 1_0101010_01011100 = 0xAA5C.
    run_cmd(0, 1'b1, 7'h2A, 8'h5C, 16'h00C3);
    check_eq("mrst_frame", 32'(last_frame[0]), 32'hAA5C);
    check_eq("mrst_rdata", 32'(rsp_rdata[0]), 32'hC3);
    check_eq("mrst_scsn_low", 32'(last_low[0]), 32'd66);

    // ClkDiv=255 write of 0xFF to address 0x00.
    run_cmd(2, 1'b1, 7'h00, 8'hFF, 16'h0000);
    check_eq("d255_frame", 32'(last_frame[2]), 32'h80FF);
    check_eq("d255_hi_min", 32'(hi_min[2]), 32'd255);
    check_eq("d255_hi_max", 32'(hi_max[2]), 32'd255);
    check_eq("d255_lo_min", 32'(lo_min[2]), 32'd255);
    check_eq("d255_lo_max", 32'(lo_max[2]), 32'd255);
    check_eq("d255_scsn_low", 32'(last_low[2]), 32'd8415);

    // MOSI must never change while SCLK is high, on any instance.
    check_eq("mosi_stable_hi", 32'(viol[0] + viol[1] + viol[2]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
